// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter.
// - arb_state_e : arbiter state; the owner status output reuses the same
//                 encoding (0 none, 1 master 0, 2 master 1).
// - DEF_ADDR_W / DEF_DATA_W : default bus widths.
// - other_own() : maps one ownership state to the opposite master's state.
package bus_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_e;

    function automatic arb_state_e other_own(input arb_state_e s);
        return (s == ARB_OWN0) ? ARB_OWN1 : ARB_OWN0;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bundle of all request/grant/data signals around the arbiter.
// - m0_* / m1_* : request side of the CPU data port and the secondary master.
// - s_*         : single CPU-side port of the bus bridge.
// - owner       : current owner status (0 none, 1 m0, 2 m1).
// Modport slave is the arbiter's own view (it serves the masters' requests);
// modport master is the view of the environment (masters plus bridge).
interface bus_arbiter_if
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              m0_req, m0_lock, m0_we, m0_gnt;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata, m0_rdata;
    logic              m1_req, m1_lock, m1_we, m1_gnt;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata, m1_rdata;
    logic [ADDR_W-1:0] s_addr;
    logic              s_we;
    logic [DATA_W-1:0] s_wdata, s_rdata;
    logic [1:0]        owner;

    modport slave (
        input  m0_req, m0_lock, m0_addr, m0_we, m0_wdata,
        input  m1_req, m1_lock, m1_addr, m1_we, m1_wdata,
        input  s_rdata,
        output m0_gnt, m0_rdata, m1_gnt, m1_rdata,
        output s_addr, s_we, s_wdata, owner
    );

    modport master (
        output m0_req, m0_lock, m0_addr, m0_we, m0_wdata,
        output m1_req, m1_lock, m1_addr, m1_we, m1_wdata,
        output s_rdata,
        input  m0_gnt, m0_rdata, m1_gnt, m1_rdata,
        input  s_addr, s_we, s_wdata, owner
    );
endinterface

// File: rtl/bus_arbiter_hold_cnt.sv
// arb_hold_cnt: saturating contention counter for the current bus owner.
// - clr_i    : restart the count (ownership change or no competing request).
// - en_i     : owner and the other master both request this cycle.
// - lock_i   : owner holds lock; count is frozen and never expires.
// - expire_o : owner is on its last contested beat; hand the bus over next.
module arb_hold_cnt #(
    parameter int MAX_HOLD = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    input  logic lock_i,
    output logic expire_o
);
    localparam int              CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expire_o = en_i & ~lock_i & (cnt_q == LAST);

    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !lock_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the bridge's CPU-side port between master 0 (CPU data
// port) and master 1 (DMA/debug loader), one beat per cycle.
// - clk, rst : system clock, asynchronous active-high reset.
// - bus      : bus_arbiter_if.slave carrying both masters and the bridge port.
// Grants come from the registered state only. Ties in IDLE go to m0 when
// CPU_PRIO=1, else to the master that did not own the bus last. An unlocked
// owner facing a waiting master is preempted after MAX_HOLD beats.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_HOLD = 16,
    parameter int CPU_PRIO = 1
) (
    input  logic clk,
    input  logic rst,
    bus_arbiter_if.slave bus
);
    arb_state_e        state_q, state_d;
    logic              last_owner_q, last_owner_d;  // 0: m0, 1: m1
    logic              own_req, oth_req, own_lock, own_we;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;
    logic              hold_en, hold_clr, hold_expire;

    // Owner-relative view of the request side; all zero in IDLE, which also
    // keeps s_addr/s_wdata/s_we at zero when nobody owns the bus.
    always_comb begin
        own_req   = 1'b0;
        oth_req   = 1'b0;
        own_lock  = 1'b0;
        own_we    = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        case (state_q)
            ARB_OWN0: begin
                own_req   = bus.m0_req;
                oth_req   = bus.m1_req;
                own_lock  = bus.m0_lock;
                own_we    = bus.m0_we;
                own_addr  = bus.m0_addr;
                own_wdata = bus.m0_wdata;
            end
            ARB_OWN1: begin
                own_req   = bus.m1_req;
                oth_req   = bus.m0_req;
                own_lock  = bus.m1_lock;
                own_we    = bus.m1_we;
                own_addr  = bus.m1_addr;
                own_wdata = bus.m1_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        case (state_q)
            ARB_IDLE: begin
                if (bus.m0_req && bus.m1_req) begin
                    state_d = ((CPU_PRIO != 0) || last_owner_q) ? ARB_OWN0 : ARB_OWN1;
                end else if (bus.m0_req) begin
                    state_d = ARB_OWN0;
                end else if (bus.m1_req) begin
                    state_d = ARB_OWN1;
                end
            end
            ARB_OWN0, ARB_OWN1: begin
                // Release and expiry lead to the same place, so release
                // needs no separate priority over preemption.
                if (!own_req || hold_expire) begin
                    state_d = oth_req ? other_own(state_q) : ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        if ((state_q != ARB_IDLE) && (state_d != state_q)) begin
            last_owner_d = (state_q == ARB_OWN1);
        end
    end

    assign hold_en  = (state_q != ARB_IDLE) & own_req & oth_req;
    assign hold_clr = (state_d != state_q) | ~oth_req;

    arb_hold_cnt #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (hold_clr),
        .en_i     (hold_en),
        .lock_i   (own_lock),
        .expire_o (hold_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            last_owner_q <= 1'b1;  // m0 wins the first round-robin tie
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Grant is implied by own_* being non-zero only in an OWN state, and the
    // async reset clears state_q, so a reset mid-beat kills s_we at once.
    assign bus.m0_gnt   = (state_q == ARB_OWN0);
    assign bus.m1_gnt   = (state_q == ARB_OWN1);
    assign bus.owner    = state_q;
    assign bus.s_addr   = own_addr;
    assign bus.s_wdata  = own_wdata;
    assign bus.s_we     = own_we & own_req;
    assign bus.m0_rdata = (state_q == ARB_OWN0) ? bus.s_rdata : '0;
    assign bus.m1_rdata = (state_q == ARB_OWN1) ? bus.s_rdata : '0;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: one instance with CPU priority and one with
// round-robin ties, both MAX_HOLD=4. Only the instance chosen by sel sees
// requests; the other stays idle.
module tb_bus_arbiter;
    localparam logic [31:0] A0 = 32'h0000_4000;
    localparam logic [31:0] A1 = 32'h8000_0010;
    localparam logic [31:0] W0 = 32'hDEAD_BEEF;
    localparam logic [31:0] W1 = 32'h0BAD_F00D;
    localparam logic [31:0] RD = 32'h1234_5678;

    typedef struct packed {
        logic        gnt0;
        logic        gnt1;
        logic [1:0]  owner;
        logic        s_we;
        logic [31:0] s_addr;
        logic [31:0] s_wdata;
        logic [31:0] rdata0;
        logic [31:0] rdata1;
    } out_t;

    typedef struct packed {
        logic       sel;
        logic       req0, lock0, we0;
        logic       req1, lock1, we1;
        logic [1:0] own;
        logic       swe;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic sel;
    logic req0, lock0, we0, req1, lock1, we1;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if_p ();
    bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if_r ();

    assign if_p.m0_req   = req0 & ~sel;
    assign if_p.m0_lock  = lock0;
    assign if_p.m0_we    = we0;
    assign if_p.m0_addr  = A0;
    assign if_p.m0_wdata = W0;
    assign if_p.m1_req   = req1 & ~sel;
    assign if_p.m1_lock  = lock1;
    assign if_p.m1_we    = we1;
    assign if_p.m1_addr  = A1;
    assign if_p.m1_wdata = W1;
    assign if_p.s_rdata  = RD;

    assign if_r.m0_req   = req0 & sel;
    assign if_r.m0_lock  = lock0;
    assign if_r.m0_we    = we0;
    assign if_r.m0_addr  = A0;
    assign if_r.m0_wdata = W0;
    assign if_r.m1_req   = req1 & sel;
    assign if_r.m1_lock  = lock1;
    assign if_r.m1_we    = we1;
    assign if_r.m1_addr  = A1;
    assign if_r.m1_wdata = W1;
    assign if_r.s_rdata  = RD;

    bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(4), .CPU_PRIO(1)) dut_p (
        .clk (clk),
        .rst (rst),
        .bus (if_p.slave)
    );

    bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(4), .CPU_PRIO(0)) dut_r (
        .clk (clk),
        .rst (rst),
        .bus (if_r.slave)
    );

    function automatic out_t sample();
        out_t o;
        if (sel) o = '{if_r.m0_gnt, if_r.m1_gnt, if_r.owner, if_r.s_we, if_r.s_addr,
                       if_r.s_wdata, if_r.m0_rdata, if_r.m1_rdata};
        else     o = '{if_p.m0_gnt, if_p.m1_gnt, if_p.owner, if_p.s_we, if_p.s_addr,
                       if_p.s_wdata, if_p.m0_rdata, if_p.m1_rdata};
        return o;
    endfunction

    // Expected outputs from the expected owner: the owner's address/data
    // reach the bridge and only the owner sees read data.
    function automatic out_t model(input logic [1:0] own, input logic swe);
        out_t o;
        o.gnt0    = (own == 2'd1);
        o.gnt1    = (own == 2'd2);
        o.owner   = own;
        o.s_we    = swe;
        o.s_addr  = (own == 2'd1) ? A0 : (own == 2'd2) ? A1 : 32'h0;
        o.s_wdata = (own == 2'd1) ? W0 : (own == 2'd2) ? W1 : 32'h0;
        o.rdata0  = (own == 2'd1) ? RD : 32'h0;
        o.rdata1  = (own == 2'd2) ? RD : 32'h0;
        return o;
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got gnt=%b%b own=%0d we=%b addr=%h wd=%h rd0=%h rd1=%h, want gnt=%b%b own=%0d we=%b addr=%h wd=%h rd0=%h rd1=%h",
                     name, act.gnt0, act.gnt1, act.owner, act.s_we, act.s_addr, act.s_wdata,
                     act.rdata0, act.rdata1, exp.gnt0, exp.gnt1, exp.owner, exp.s_we,
                     exp.s_addr, exp.s_wdata, exp.rdata0, exp.rdata1);
        end
    endtask

    // Inputs are already set just after a falling edge; compare mid-cycle,
    // then move on to the next falling edge.
    task automatic apply(input string name, input logic [1:0] own, input logic swe);
        #1;
        check(name, sample(), model(own, swe));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input logic s, input logic r0, input logic l0, input logic w0,
                          input logic r1, input logic l1, input logic w1);
        sel = s; req0 = r0; lock0 = l0; we0 = w0; req1 = r1; lock1 = l1; we1 = w1;
    endtask

    task automatic add(input logic s, input logic r0, input logic l0, input logic w0,
                       input logic r1, input logic l1, input logic w1,
                       input logic [1:0] own, input logic swe);
        vecs.push_back({s, r0, l0, w0, r1, l1, w1, own, swe});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0);

        // CPU priority instance: single write beat, then a tie and a release
        // straight into the waiting master.
        //   sel r0 l0 w0 r1 l1 w1 own swe
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 1, 1, 0);
        add(0, 1, 0, 0, 1, 0, 1, 1, 0);
        add(0, 1, 0, 0, 1, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1, 0, 1, 2, 1);
        add(0, 0, 0, 0, 0, 0, 1, 2, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Round-robin instance: continuous contention alternates every 4
        // beats, then an IDLE tie goes to the master that was not last.
        add(1, 1, 0, 1, 1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) add(1, 1, 0, 1, 1, 0, 1, 1, 1);
        for (int i = 0; i < 4; i++) add(1, 1, 0, 1, 1, 0, 1, 2, 1);
        add(1, 1, 0, 1, 1, 0, 1, 1, 1);
        add(1, 0, 0, 1, 0, 0, 1, 1, 0);
        add(1, 1, 0, 0, 1, 0, 1, 0, 0);
        add(1, 1, 0, 0, 1, 0, 1, 2, 1);
        add(1, 1, 0, 0, 0, 0, 1, 2, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        check("reset_state", sample(), model(2'd0, 1'b0));
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            set_in(vecs[i].sel, vecs[i].req0, vecs[i].lock0, vecs[i].we0,
                   vecs[i].req1, vecs[i].lock1, vecs[i].we1);
            apply($sformatf("vec%0d", i), vecs[i].own, vecs[i].swe);
        end

        // Locked m1 is never preempted; after unlock it gets 4 contested
        // beats. m0's own lock is ignored while it waits, then honoured.
        set_in(1, 0, 0, 0, 1, 1, 0);
        apply("lock_grant_m1", 2'd0, 1'b0);
        set_in(1, 1, 1, 1, 1, 1, 0);
        for (int i = 0; i < 20; i++) apply($sformatf("lock1_hold%0d", i), 2'd2, 1'b0);
        lock1 = 1'b0;
        for (int i = 0; i < 4; i++) apply($sformatf("unlock1_beat%0d", i), 2'd2, 1'b0);
        for (int i = 0; i < 6; i++) apply($sformatf("lock0_hold%0d", i), 2'd1, 1'b1);
        lock0 = 1'b0;
        for (int i = 0; i < 4; i++) apply($sformatf("unlock0_beat%0d", i), 2'd1, 1'b1);
        apply("handback_m1", 2'd2, 1'b0);
        set_in(1, 0, 0, 0, 0, 0, 0);
        apply("lock_release", 2'd2, 1'b0);
        apply("lock_idle", 2'd0, 1'b0);

        // Reset in the middle of an m0 write beat.
        set_in(0, 1, 0, 1, 0, 0, 0);
        apply("rst_req", 2'd0, 1'b0);
        #1;
        check("rst_pre_write", sample(), model(2'd1, 1'b1));
        rst = 1'b1;
        #1;
        check("rst_mid_write", sample(), model(2'd0, 1'b0));
        set_in(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) apply($sformatf("rst_idle%0d", i), 2'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
